// File: rtl/pwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_pkg                                                            |
// | Shared ramp FSM state type and width defaults for the PWM ramp.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pwm_pkg;

    localparam int c_duty_w_dflt  = 8;
    localparam int c_pre_w_dflt   = 11;
    // Step period is 2^(speed + c_pre_exp_off) cycles.
    localparam int c_pre_exp_off  = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2
    } ramp_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_core                                                           |
// | Free-running period counter, period-aligned shadow duty, and       |
// | registered comparator producing the PWM waveform.                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pwm_core #(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    localparam logic [DUTY_W-1:0] c_cnt_max = {DUTY_W{1'b1}};

    logic [DUTY_W-1:0] r_cnt;
    logic [DUTY_W-1:0] r_duty_applied;
    logic              r_pwm;

    // Shadow duty only changes on the last count so a period is never split.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_duty_applied <= '0;
            r_pwm          <= 1'b0;
        end else if (!enable) begin
            r_cnt          <= '0;
            r_pwm          <= 1'b0;
        end else begin
            r_cnt <= r_cnt + DUTY_W'(1);
            if (r_cnt == c_cnt_max) begin
                r_duty_applied <= duty;
            end
            r_pwm <= (r_cnt < r_duty_applied);
        end
    end

    assign pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_ramp_ctrl                                                      |
// | Ramps a PWM duty cycle toward a loaded target at a selectable rate.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int DUTY_W = c_duty_w_dflt,
    parameter int PRE_W  = c_pre_w_dflt
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [2:0]        speed,
    input  logic [DUTY_W-1:0] target,
    input  logic              load,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              done,
    output logic              pwm
);

    ramp_state_t       r_state;
    ramp_state_t       w_state_nxt;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic [DUTY_W-1:0] r_target_q;
    logic [DUTY_W-1:0] w_target_nxt;
    logic [2:0]        r_speed_q;
    logic [2:0]        w_speed_nxt;
    logic [PRE_W-1:0]  r_pre;
    logic [PRE_W-1:0]  w_pre_nxt;
    logic [PRE_W-1:0]  w_pre_tc;
    logic [3:0]        w_pre_exp;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_tick;
    logic [DUTY_W-1:0] w_duty_step;

    assign w_pre_exp   = {1'b0, r_speed_q} + 4'(c_pre_exp_off);
    assign w_pre_tc    = (PRE_W'(1) << w_pre_exp) - PRE_W'(1);
    assign w_tick      = (r_state != ST_IDLE) && (r_pre == w_pre_tc);
    assign w_duty_step = (r_state == ST_RAMP_UP) ? (r_duty + DUTY_W'(1))
                                                 : (r_duty - DUTY_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_duty     <= '0;
            r_target_q <= '0;
            r_speed_q  <= '0;
            r_pre      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_target_q <= w_target_nxt;
            r_speed_q  <= w_speed_nxt;
            r_pre      <= w_pre_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Priority: enable low aborts, then load (beats a coincident tick), then ramp.
    always_comb begin
        w_state_nxt  = r_state;
        w_duty_nxt   = r_duty;
        w_target_nxt = r_target_q;
        w_speed_nxt  = r_speed_q;
        w_pre_nxt    = r_pre;
        w_done_nxt   = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_pre_nxt   = '0;
        end else if (load) begin
            w_target_nxt = target;
            w_speed_nxt  = speed;
            w_pre_nxt    = '0;
            if (target > r_duty) begin
                w_state_nxt = ST_RAMP_UP;
            end else if (target < r_duty) begin
                w_state_nxt = ST_RAMP_DOWN;
            end else begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
        end else begin
            case (r_state)
                ST_RAMP_UP, ST_RAMP_DOWN: begin
                    if (w_tick) begin
                        w_duty_nxt = w_duty_step;
                        w_pre_nxt  = '0;
                        if (w_duty_step == r_target_q) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_pre_nxt = r_pre + PRE_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_pre_nxt   = '0;
                end
            endcase
        end
    end

    pwm_core #(
        .DUTY_W (DUTY_W)
    ) u_pwm_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .duty   (r_duty),
        .pwm    (pwm)
    );

    assign duty = r_duty;
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pwm_ramp_ctrl                                                   |
// | Vector table, directed corner sequences and random stimulus        |
// | against a cycle-level behavioural model of the ramp and PWM.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [7:0] target = 8'd0;
    logic [7:0] duty;
    logic       busy;
    logic       done;
    logic       pwm;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.DUTY_W(8), .PRE_W(11)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .speed  (speed),
        .target (target),
        .load   (load),
        .duty   (duty),
        .busy   (busy),
        .done   (done),
        .pwm    (pwm)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: ramp described as "cycles elapsed since anchor vs step period".
    int m_duty, m_tgt, m_per, m_elapsed, m_cnt, m_app;
    bit m_busy, m_done, m_pwm;

    typedef struct {
        bit en; bit ld; int sp; int tg; int cyc;
        int e_duty; bit e_busy; bit e_done;
    } vec_t;
    vec_t tbl[13];

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_duty = 0; m_tgt = 0; m_per = 8; m_elapsed = 0;
        m_cnt = 0; m_app = 0; m_busy = 0; m_done = 0; m_pwm = 0;
    endtask

    task automatic model_next(bit en, bit ld, int sp, int tg);
        bit n_pwm;
        int n_app, n_cnt;
        n_pwm = en && (m_cnt < m_app);
        n_app = (en && m_cnt == 255) ? m_duty : m_app;
        n_cnt = en ? (m_cnt + 1) % 256 : 0;
        m_done = 0;
        if (!en) begin
            m_busy = 0;
            m_elapsed = 0;
        end else if (ld) begin
            m_tgt = tg;
            m_per = 1 << (sp + 3);
            m_elapsed = 0;
            m_busy = (tg != m_duty);
            m_done = (tg == m_duty);
        end else if (m_busy) begin
            m_elapsed++;
            if (m_elapsed == m_per) begin
                m_duty += (m_tgt > m_duty) ? 1 : -1;
                m_elapsed = 0;
                if (m_duty == m_tgt) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
        m_pwm = n_pwm; m_app = n_app; m_cnt = n_cnt;
    endtask

    task automatic step(bit en, bit ld, int sp, int tg);
        enable = en; load = ld; speed = 3'(sp); target = 8'(tg);
        model_next(en, ld, sp, tg);
        @(posedge clk);
        #1;
        check("model{duty,busy,done,pwm}", int'({duty, busy, done, pwm}),
              int'({8'(m_duty), m_busy, m_done, m_pwm}));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; load = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", int'({duty, busy, done, pwm}), 0);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            step(1, 0, 0, 0);
            k++;
        end
        check("wait_idle_timeout", int'(busy), 0);
    endtask

    task automatic count_pwm(output int hi);
        hi = 0;
        repeat (256) begin
            step(1, 0, 0, 0);
            hi += int'(pwm);
        end
    endtask

    initial begin
        int hi;
        model_reset();

        //          en ld sp tg  cyc duty busy done
        tbl[0]  = '{1, 1, 0, 4,   1, 0, 1, 0};
        tbl[1]  = '{1, 0, 0, 0,   7, 0, 1, 0};
        tbl[2]  = '{1, 0, 0, 0,   1, 1, 1, 0};
        tbl[3]  = '{1, 0, 0, 0,   8, 2, 1, 0};
        tbl[4]  = '{1, 0, 0, 0,  16, 4, 0, 1};
        tbl[5]  = '{1, 0, 0, 0,   1, 4, 0, 0};
        tbl[6]  = '{1, 1, 1, 1,   1, 4, 1, 0};
        tbl[7]  = '{1, 0, 0, 0,  16, 3, 1, 0};
        tbl[8]  = '{1, 0, 0, 0,  32, 1, 0, 1};
        tbl[9]  = '{1, 0, 0, 0,   1, 1, 0, 0};
        tbl[10] = '{1, 1, 0, 1,   1, 1, 0, 1};
        tbl[11] = '{1, 0, 0, 0,   1, 1, 0, 0};
        tbl[12] = '{0, 0, 0, 0,   1, 1, 0, 0};

        do_reset();

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].en, tbl[i].ld, tbl[i].sp, tbl[i].tg);
            for (int k = 1; k < tbl[i].cyc; k++) step(tbl[i].en, 0, 0, 0);
            check($sformatf("tbl[%0d]{duty,busy,done}", i), int'({duty, busy, done}),
                  int'({8'(tbl[i].e_duty), tbl[i].e_busy, tbl[i].e_done}));
        end

        // Abort while ramping up at duty 3.
        step(1, 1, 0, 10);
        repeat (16) step(1, 0, 0, 0);
        check("abort_pre_duty", int'(duty), 3);
        step(0, 0, 0, 0);
        check("abort{duty,busy,done,pwm}", int'({duty, busy, done, pwm}), int'({8'd3, 3'b000}));

        // Load with target equal to duty.
        step(1, 1, 0, 3);
        check("equal_load{busy,done}", int'({busy, done}), 1);
        step(1, 0, 0, 0);
        check("equal_load_done_clear", int'(done), 0);

        // Reversal load on the cycle that would otherwise tick.
        step(1, 1, 0, 8);
        repeat (7) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check("load_at_tick{duty,busy}", int'({duty, busy}), int'({8'd3, 1'b1}));
        repeat (8) step(1, 0, 0, 0);
        check("reversed_step", int'(duty), 2);
        wait_idle(200);
        check("ramp_to_zero", int'(duty), 0);

        // Zero duty produces no high cycles.
        repeat (300) step(1, 0, 0, 0);
        count_pwm(hi);
        check("pwm_high_duty0", hi, 0);

        // Slowest rate: first step 1024 cycles after load.
        step(1, 1, 7, 1);
        repeat (1023) step(1, 0, 0, 0);
        check("speed7_before", int'(duty), 0);
        step(1, 0, 0, 0);
        check("speed7_step{duty,done}", int'({duty, done}), int'({8'd1, 1'b1}));

        // Half duty, then maximum duty.
        step(1, 1, 0, 128);
        wait_idle(2000);
        repeat (300) step(1, 0, 0, 0);
        count_pwm(hi);
        check("pwm_high_duty128", hi, 128);
        step(1, 1, 0, 255);
        wait_idle(2000);
        repeat (300) step(1, 0, 0, 0);
        count_pwm(hi);
        check("pwm_high_duty255", hi, 255);

        // Asynchronous reset mid-ramp at duty 5.
        do_reset();
        step(1, 1, 0, 10);
        repeat (40) step(1, 0, 0, 0);
        check("pre_reset_duty", int'(duty), 5);
        #2 rst_n = 1'b0;
        #1 check("async_reset{duty,busy,done,pwm}", int'({duty, busy, done, pwm}), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_reset_busy", int'(busy), 0);
        step(1, 1, 0, 2);
        repeat (16) step(1, 0, 0, 0);
        check("post_reset_ramp{duty,done}", int'({duty, done}), int'({8'd2, 1'b1}));

        // Random traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            step(($urandom_range(0, 99) < 96),
                 ($urandom_range(0, 99) < 3),
                 int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
